// File: rtl/alu_if.sv
// Operand/opcode/result bundle between the sequencer and the accumulator ALU.
interface alu_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in;
    logic [2:0]       control;
    logic [WIDTH-1:0] accumulator;
    logic [3:0]       flags;

    // Sequencer side: drives operand and opcode, observes result.
    modport master (
        output in,
        output control,
        input  accumulator,
        input  flags
    );

    // ALU side: consumes operand and opcode, presents registered result.
    modport slave (
        input  in,
        input  control,
        output accumulator,
        output flags
    );
endinterface

// File: rtl/alu.sv
// Single-accumulator ALU: eight opcodes applied to the accumulator and `in`
// each cycle, with a registered Z/N/C/V status word describing the new value.
module alu #(
    parameter int WIDTH = 8
) (
    input logic   clk,
    input logic   reset,
    alu_if.slave  bus
);
    localparam logic [2:0] OP_HOLD  = 3'd0;
    localparam logic [2:0] OP_CLEAR = 3'd1;
    localparam logic [2:0] OP_ADD   = 3'd2;
    localparam logic [2:0] OP_SUB   = 3'd3;
    localparam logic [2:0] OP_AND   = 3'd4;
    localparam logic [2:0] OP_NEG   = 3'd5;
    localparam logic [2:0] OP_NOT   = 3'd6;
    localparam logic [2:0] OP_XOR   = 3'd7;

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   sub_ext;
    logic [WIDTH-1:0] neg_res;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             ovf;

    // Next accumulator value and status for the selected opcode.
    always_comb begin
        add_ext = {1'b0, acc_q} + {1'b0, bus.in};
        // Top bit of the extended difference is the unsigned borrow.
        sub_ext = {1'b0, acc_q} - {1'b0, bus.in};
        neg_res = '0 - acc_q;
        res     = acc_q;
        carry   = 1'b0;
        ovf     = 1'b0;

        case (bus.control)
            OP_CLEAR: res = '0;
            OP_ADD: begin
                res   = add_ext[WIDTH-1:0];
                carry = add_ext[WIDTH];
                ovf   = (acc_q[WIDTH-1] == bus.in[WIDTH-1]) &&
                        (res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_SUB: begin
                res   = sub_ext[WIDTH-1:0];
                carry = sub_ext[WIDTH];
                ovf   = (acc_q[WIDTH-1] != bus.in[WIDTH-1]) &&
                        (res[WIDTH-1] != acc_q[WIDTH-1]);
            end
            OP_AND: res = acc_q & bus.in;
            OP_NEG: begin
                res   = neg_res;
                carry = |acc_q;
                ovf   = (acc_q == MOST_NEG);
            end
            OP_NOT: res = ~acc_q;
            OP_XOR: res = acc_q ^ bus.in;
            default: res = acc_q;
        endcase

        acc_d = res;
        if (bus.control == OP_HOLD) begin
            flags_d = flags_q;
        end else begin
            flags_d = {ovf, carry, res[WIDTH-1], (res == '0)};
        end
    end

    // Accumulator and status registers; reset overrides any opcode.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            flags_q <= 4'b0001;
        end else begin
            acc_q   <= acc_d;
            flags_q <= flags_d;
        end
    end

    assign bus.accumulator = acc_q;
    assign bus.flags       = flags_q;
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu (WIDTH=8): directed corner cases followed by
// random opcode/operand traffic against an integer-arithmetic reference model.
module tb_alu;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   m_acc;
    logic [3:0] m_flags;

    alu_if #(.WIDTH(8)) bus ();

    alu #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model in plain integer arithmetic on the 0..255 range.
    task automatic model_step(input bit rst, input int op, input int b);
        int a, sa, sb, s, r;
        bit c, v;
        if (rst) begin
            m_acc   = 0;
            m_flags = 4'b0001;
            return;
        end
        a  = m_acc;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r  = a;
        c  = 0;
        v  = 0;
        case (op)
            0: return;
            1: r = 0;
            2: begin
                s = a + b;
                r = s % 256;
                c = (s > 255);
                v = (sa + sb > 127) || (sa + sb < -128);
            end
            3: begin
                s = a - b;
                r = (s + 256) % 256;
                c = (a < b);
                v = (sa - sb > 127) || (sa - sb < -128);
            end
            4: r = a & b;
            5: begin
                r = (256 - a) % 256;
                c = (a != 0);
                v = (-sa > 127);
            end
            6: r = 255 - a;
            default: r = a ^ b;
        endcase
        m_acc   = r;
        m_flags = {v, c, (r >= 128), (r == 0)};
    endtask

    task automatic step(input bit rst, input logic [2:0] op, input logic [7:0] b);
        reset       = rst;
        bus.control = op;
        bus.in      = b;
        @(posedge clk);
        #1;
        model_step(rst, int'(op), int'(b));
    endtask

    task automatic check(input string tag, input logic [7:0] ea, input logic [3:0] ef);
        total++;
        assert (bus.accumulator === ea && bus.flags === ef)
        else begin
            bad++;
            $error("FAIL %s: acc=%h flags=%b, expected acc=%h flags=%b",
                   tag, bus.accumulator, bus.flags, ea, ef);
        end
    endtask

    initial begin
        logic [7:0] ea;
        logic [2:0] rop;
        logic [7:0] rin;
        bit         rrst;
        clk   = 0;
        total = 0;
        bad   = 0;
        m_acc = 0;
        m_flags = 4'b0001;

        step(1, 3'd2, 8'h33);
        step(1, 3'd2, 8'h33);
        check("reset", 8'h00, 4'b0001);

        step(0, 3'd0, 8'hAA); check("hold0", 8'h00, 4'b0001);
        step(0, 3'd1, 8'h55); check("clear", 8'h00, 4'b0001);
        step(0, 3'd2, 8'h05); check("add05", 8'h05, 4'b0000);
        step(0, 3'd3, 8'h03); check("sub03", 8'h02, 4'b0000);
        step(0, 3'd5, 8'h77); check("neg",   8'hFE, 4'b0110);
        step(0, 3'd6, 8'h11); check("not",   8'h01, 4'b0000);
        step(0, 3'd7, 8'h09); check("xor09", 8'h08, 4'b0000);
        step(0, 3'd4, 8'h0C); check("and0c", 8'h08, 4'b0000);

        step(0, 3'd1, 8'h00);
        step(0, 3'd2, 8'h7F);
        step(0, 3'd2, 8'h01); check("add_ovf", 8'h80, 4'b1010);
        step(0, 3'd1, 8'h00);
        step(0, 3'd2, 8'hFF);
        step(0, 3'd2, 8'h01); check("add_carry", 8'h00, 4'b0101);

        step(0, 3'd1, 8'h00);
        step(0, 3'd3, 8'h01); check("sub_borrow", 8'hFF, 4'b0110);
        step(0, 3'd1, 8'h00);
        step(0, 3'd2, 8'h80);
        step(0, 3'd3, 8'h01); check("sub_ovf", 8'h7F, 4'b1000);

        step(0, 3'd1, 8'h00);
        step(0, 3'd2, 8'h80);
        step(0, 3'd5, 8'h00); check("neg80", 8'h80, 4'b1110);
        step(0, 3'd1, 8'h00);
        step(0, 3'd5, 8'hFF); check("neg00", 8'h00, 4'b0001);

        step(0, 3'd1, 8'h00);
        step(0, 3'd2, 8'h02);
        step(0, 3'd5, 8'h00); check("neg_fe", 8'hFE, 4'b0110);
        step(0, 3'd0, 8'hFF); check("hold1", 8'hFE, 4'b0110);
        step(0, 3'd0, 8'h00); check("hold2", 8'hFE, 4'b0110);
        step(0, 3'd0, 8'hA5); check("hold3", 8'hFE, 4'b0110);

        step(0, 3'd1, 8'h00);
        step(0, 3'd2, 8'h5A);
        step(1, 3'd2, 8'h10); check("reset_mid", 8'h00, 4'b0001);
        step(0, 3'd2, 8'h10); check("after_reset", 8'h10, 4'b0000);

        for (int i = 0; i < 400; i++) begin
            rop  = 3'($urandom_range(0, 7));
            rin  = 8'($urandom_range(0, 255));
            rrst = ($urandom_range(0, 31) == 0);
            step(rrst, rop, rin);
            ea = m_acc[7:0];
            check("random", ea, m_flags);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
